// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Streams machine words into instruction memory from address 0,
//            launches the core with a one-cycle req, then times its run.
// Revision : 1.0
// ============================================================================
module prog_loader #(
    parameter int D          = 12,
    parameter int W          = 9,
    parameter int C          = 16,
    parameter int MAX_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic         core_req,
    input  logic         core_done,
    output logic         busy,
    output logic         finished,
    output logic [D-1:0] prog_len,
    output logic [C-1:0] cycle_count,
    output logic         timeout
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FLUSH  = 3'd2,
        LAUNCH = 3'd3,
        RUN    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [C-1:0] CYC_LIMIT = C'(MAX_CYCLES - 1);

    state_t       state_q, state_d;
    logic [D-1:0] ptr_q, ptr_d;
    logic [C-1:0] cycles_q, cycles_d;
    logic         timeout_q, timeout_d;
    logic         wr_en_q, wr_en_d;
    logic [D-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0] wr_data_q, wr_data_d;
    logic         xfer;

    assign xfer = (state_q == LOAD) && in_valid;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        wr_en_d   = xfer;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            wr_addr_d = ptr_q;
            wr_data_d = in_data;
        end
        case (state_q)
            IDLE: begin
                ptr_d     = '0;
                cycles_d  = '0;
                timeout_d = 1'b0;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (in_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    // The top address closes the load even without in_last.
                    if (in_last || (ptr_q == {D{1'b1}})) state_d = FLUSH;
                end
            end
            FLUSH:  state_d = LAUNCH;
            LAUNCH: begin
                cycles_d = '0;
                state_d  = RUN;
            end
            RUN: begin
                if (core_done) begin
                    timeout_d = 1'b0;
                    state_d   = DONE;
                end else if (cycles_q == CYC_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cycles_d = cycles_q + 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    ptr_d     = '0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Strobes are gated by reset so they fall in the cycle reset is raised.
    assign wr_en       = wr_en_q && !reset;
    assign core_req    = (state_q == LAUNCH) && !reset;
    assign in_ready    = (state_q == LOAD);
    assign busy        = (state_q == LOAD) || (state_q == FLUSH) ||
                         (state_q == LAUNCH) || (state_q == RUN);
    assign finished    = (state_q == DONE);
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign prog_len    = ptr_q;
    assign cycle_count = cycles_q;
    assign timeout     = timeout_q;

endmodule
`default_nettype wire
